// File: rtl/sensor_ascii_pkg.sv
// Shared types and constants for the sensor ASCII line formatter.
package sensor_ascii_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CONV = 3'd1,
    ST_EMIT = 3'd2,
    ST_SEP  = 3'd3,
    ST_CR   = 3'd4,
    ST_LF   = 3'd5
  } state_t;

  localparam logic [7:0] COLON = 8'h3A;
  localparam logic [7:0] COMMA = 8'h2C;
  localparam logic [7:0] CR    = 8'h0D;
  localparam logic [7:0] LF    = 8'h0A;
  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] ZERO  = 8'h30;

  function automatic int pow10(input int n);
    int p;
    p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  // Largest value printable in n decimal digits.
  function automatic int max_val(input int n);
    return pow10(n) - 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: DATA_W cycles from load to done.
module bin2bcd_seq #(
  parameter int DATA_W = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  logic [DATA_W-1:0]   sh_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] adj;
  logic [4:0]          cnt_q;
  logic                done_q;

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  // The load cycle already performs the first shift (no add-3 needed on zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q   <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else if (load) begin
      sh_q   <= bin << 1;
      bcd_q  <= {{(4*DIGITS-1){1'b0}}, bin[DATA_W-1]};
      cnt_q  <= 5'(DATA_W - 1);
      done_q <= 1'b0;
    end else if (cnt_q != 5'd0) begin
      sh_q   <= sh_q << 1;
      bcd_q  <= {adj[4*DIGITS-2:0], sh_q[DATA_W-1]};
      cnt_q  <= cnt_q - 5'd1;
      if (cnt_q == 5'd1) done_q <= 1'b1;
    end
  end

  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/sensor_ascii_fmt.sv
// Multi-channel sensor snapshot to ASCII line streamer (valid/ready byte output).
// Optional leading-zero blanking: define SENSOR_ASCII_LZB_EN.
module sensor_ascii_fmt
  import sensor_ascii_pkg::*;
#(
  parameter int                   NUM_CH = 2,
  parameter int                   DATA_W = 8,
  parameter int                   DIGITS = 3,
  parameter logic [16*NUM_CH-1:0] LABELS = "RHT ",
  parameter logic [8*NUM_CH-1:0]  UNITS  = "%C"
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] data_in,
  input  logic                     start,
  output logic                     busy,
  output logic [7:0]               tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     overrun,
  output logic                     sat,
  output logic [2:0]               state_dbg
);

  // Handshake: a byte moves on any cycle with tx_valid && tx_ready; while
  // tx_valid && !tx_ready the state (and so tx_data) is frozen.

  localparam int MAXV = max_val(DIGITS);
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS + 3);

  state_t                    state_q, state_d;
  logic [CHW-1:0]            ch_q, ch_d;
  logic [3:0]                idx_q, idx_d;
  logic                      conv_ld_q, conv_ld_d;
  logic [NUM_CH*DATA_W-1:0]  snap_q;

  logic [DATA_W-1:0]         cur_val, conv_bin;
  logic                      clamp_hit, cv_load, cv_done;
  logic [4*DIGITS-1:0]       bcd;
  logic [15:0]               lab;
  logic [7:0]                unit, field_byte;

  bin2bcd_seq #(.DATA_W(DATA_W), .DIGITS(DIGITS)) u_conv (
    .clk  (clk),
    .rst  (rst),
    .load (cv_load),
    .bin  (conv_bin),
    .done (cv_done),
    .bcd  (bcd)
  );

  assign cur_val   = snap_q[(NUM_CH-1-int'(ch_q))*DATA_W +: DATA_W];
  assign clamp_hit = 32'(cur_val) > 32'(MAXV);
  assign conv_bin  = clamp_hit ? DATA_W'(MAXV) : cur_val;
  assign lab       = LABELS[(NUM_CH-1-int'(ch_q))*16 +: 16];
  assign unit      = UNITS[(NUM_CH-1-int'(ch_q))*8 +: 8];

`ifdef SENSOR_ASCII_LZB_EN
  logic [DIGITS-1:0] blank;
  always_comb begin
    logic run;
    run   = 1'b1;
    blank = '0;
    for (int p = DIGITS-1; p >= 0; p--) begin
      run = run && (bcd[4*p +: 4] == 4'd0);
      if (p != 0) blank[p] = run;
    end
  end
`endif

  always_comb begin
    int dpos;
    dpos       = 0;
    field_byte = 8'h00;
    if (idx_q == 4'd0)          field_byte = lab[15:8];
    else if (idx_q == 4'd1)     field_byte = lab[7:0];
    else if (idx_q == 4'd2)     field_byte = COLON;
    else if (idx_q == LAST_IDX) field_byte = unit;
    else begin
      dpos       = DIGITS + 2 - int'(idx_q);
      field_byte = ZERO + {4'h0, bcd[4*dpos +: 4]};
`ifdef SENSOR_ASCII_LZB_EN
      if (blank[dpos]) field_byte = SPACE;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    idx_d     = idx_q;
    conv_ld_d = conv_ld_q;
    tx_valid  = 1'b0;
    tx_data   = 8'h00;
    cv_load   = 1'b0;
    sat       = 1'b0;
    overrun   = start && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_CONV;
          ch_d      = '0;
          conv_ld_d = 1'b0;
        end
      end
      ST_CONV: begin
        // First CONV cycle loads the converter; done is only trusted after that.
        if (!conv_ld_q) begin
          cv_load   = 1'b1;
          sat       = clamp_hit;
          conv_ld_d = 1'b1;
        end else if (cv_done) begin
          state_d = ST_EMIT;
          idx_d   = '0;
        end
      end
      ST_EMIT: begin
        tx_valid = 1'b1;
        tx_data  = field_byte;
        if (tx_ready) begin
          if (idx_q == LAST_IDX) state_d = (int'(ch_q) < NUM_CH-1) ? ST_SEP : ST_CR;
          else                   idx_d   = idx_q + 4'd1;
        end
      end
      ST_SEP: begin
        tx_valid = 1'b1;
        tx_data  = COMMA;
        if (tx_ready) begin
          ch_d      = ch_q + 1'b1;
          conv_ld_d = 1'b0;
          state_d   = ST_CONV;
        end
      end
      ST_CR: begin
        tx_valid = 1'b1;
        tx_data  = CR;
        if (tx_ready) state_d = ST_LF;
      end
      ST_LF: begin
        tx_valid = 1'b1;
        tx_data  = LF;
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ch_q      <= '0;
      idx_q     <= '0;
      conv_ld_q <= 1'b0;
      snap_q    <= '0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      idx_q     <= idx_d;
      conv_ld_q <= conv_ld_d;
      if (state_q == ST_IDLE && start) snap_q <= data_in;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_sensor_ascii_fmt.sv
// Bench for sensor_ascii_fmt: instance 0 uses defaults, instance 1 uses DIGITS=2.
module tb_sensor_ascii_fmt;

  localparam int DW = 8;

  logic        clk, rst;
  logic [15:0] data_in [2];
  logic        start [2];
  logic        tx_ready [2];
  logic        busy [2];
  logic        tx_valid [2];
  logic [7:0]  tx_data [2];
  logic        overrun [2];
  logic        sat [2];
  logic [2:0]  state_dbg [2];

  int dig [2] = '{3, 2};
  int rmode [2];
  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  logic [7:0] got0_q[$];
  logic [7:0] line_q[$];
  bit         exp_busy [2];
  bit         prev_stall [2];
  logic [7:0] prev_data [2];
  bit         want_first [2];
  int         acc_cyc [2];
  int         sat_seen [2];
  int         exp_sat [2];
  bit         lzb;

  sensor_ascii_fmt u_dut0 (
    .clk(clk), .rst(rst), .data_in(data_in[0]), .start(start[0]), .busy(busy[0]),
    .tx_data(tx_data[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .overrun(overrun[0]), .sat(sat[0]), .state_dbg(state_dbg[0])
  );

  sensor_ascii_fmt #(.DIGITS(2)) u_dut1 (
    .clk(clk), .rst(rst), .data_in(data_in[1]), .start(start[1]), .busy(busy[1]),
    .tx_data(tx_data[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .overrun(overrun[1]), .sat(sat[1]), .state_dbg(state_dbg[1])
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[dut%0d] @cyc %0d: got %0h want %0h", name, i, cyc, act, exp);
    end
  endtask

  // Reference line: labels/units fixed by the default parameters.
  task automatic model_line(input int d, input int v0, input int v1);
    int v [2];
    int mx, c, p10;
    logic [7:0] l0 [2];
    logic [7:0] l1 [2];
    logic [7:0] un [2];
    v[0] = v0; v[1] = v1;
    l0 = '{8'h52, 8'h54}; l1 = '{8'h48, 8'h20}; un = '{8'h25, 8'h43};
    mx = 10**d - 1;
    line_q.delete();
    for (int k = 0; k < 2; k++) begin
      c = (v[k] > mx) ? mx : v[k];
      line_q.push_back(l0[k]);
      line_q.push_back(l1[k]);
      line_q.push_back(8'h3A);
      for (int p = d-1; p >= 0; p--) begin
        p10 = 10**p;
        if (lzb && p > 0 && c < p10) line_q.push_back(8'h20);
        else line_q.push_back(8'(8'h30 + (c / p10) % 10));
      end
      line_q.push_back(un[k]);
      if (k == 0) line_q.push_back(8'h2C);
    end
    line_q.push_back(8'h0D);
    line_q.push_back(8'h0A);
  endtask

  task automatic cmp_lit(input string name, input string s, input bit use_got);
    int n;
    n = use_got ? got0_q.size() : line_q.size();
    chk({name, "_len"}, 0, n, s.len());
    for (int k = 0; k < n && k < s.len(); k++)
      chk({name, "_byte"}, 0, use_got ? got0_q[k] : line_q[k], s[k]);
  endtask

  // ---------------- scoreboard / compare ----------------
  task automatic check_inst(input int i);
    bit was_busy;
    int qs;
    logic [7:0] e;
    if (rst) begin
      chk("rst_busy", i, busy[i], 0);
      chk("rst_valid", i, tx_valid[i], 0);
      chk("rst_data", i, tx_data[i], 0);
      chk("rst_overrun", i, overrun[i], 0);
      chk("rst_sat", i, sat[i], 0);
      if (i == 0) exp_q0.delete(); else exp_q1.delete();
      exp_busy[i] = 0; prev_stall[i] = 0; want_first[i] = 0;
      return;
    end
    was_busy = exp_busy[i];
    chk("busy", i, busy[i], was_busy);
    chk("overrun", i, overrun[i], start[i] && was_busy);
    if (sat[i]) sat_seen[i]++;
    if (!was_busy) chk("idle_valid", i, tx_valid[i], 0);
    if (prev_stall[i]) begin
      chk("hold_valid", i, tx_valid[i], 1);
      chk("hold_data", i, tx_data[i], prev_data[i]);
    end
    if (tx_valid[i] && want_first[i]) begin
      chk("first_latency", i, cyc - acc_cyc[i], DW + 2);
      want_first[i] = 0;
    end
    if (tx_valid[i] && tx_ready[i]) begin
      qs = (i == 0) ? exp_q0.size() : exp_q1.size();
      if (qs == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL extra_byte[dut%0d]: got %0h want none", i, tx_data[i]);
      end else begin
        e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("byte", i, tx_data[i], e);
        if (i == 0) got0_q.push_back(tx_data[i]);
        if (qs == 1) exp_busy[i] = 0;
      end
    end
    prev_stall[i] = tx_valid[i] && !tx_ready[i];
    prev_data[i]  = tx_data[i];
    if (start[i] && !was_busy) begin
      model_line(dig[i], int'(data_in[i][15:8]), int'(data_in[i][7:0]));
      foreach (line_q[k]) if (i == 0) exp_q0.push_back(line_q[k]); else exp_q1.push_back(line_q[k]);
      if (int'(data_in[i][15:8]) > 10**dig[i] - 1) exp_sat[i]++;
      if (int'(data_in[i][7:0])  > 10**dig[i] - 1) exp_sat[i]++;
      exp_busy[i] = 1; acc_cyc[i] = cyc; want_first[i] = 1;
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) check_inst(i);
  end

  // ---------------- drivers ----------------
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      case (rmode[i])
        1:       tx_ready[i] = 1'($urandom_range(0, 1));
        2:       tx_ready[i] = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: tx_ready[i] = 1'b1;
      endcase
    end
  end

  task automatic do_start(input int i, input int v0, input int v1);
    @(posedge clk); #1;
    data_in[i] = {8'(v0), 8'(v1)};
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
    data_in[i] = 16'($urandom);
  endtask

  task automatic wait_done(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while ((exp_busy[i] || busy[i]) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      n_cmp++; n_fail++;
      $display("FAIL timeout[dut%0d]: busy=%0d after %0d cycles, want idle", i, busy[i], n);
    end
  endtask

  task automatic pulse_start(input int i);
    @(posedge clk); #1;
    start[i] = 1'b1;
    @(posedge clk); #1;
    start[i] = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
`ifdef SENSOR_ASCII_LZB_EN
    lzb = 1;
`else
    lzb = 0;
`endif
    rst = 0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 0; data_in[i] = '0; tx_ready[i] = 1; rmode[i] = 0;
      sat_seen[i] = 0; exp_sat[i] = 0; exp_busy[i] = 0;
    end
    #2 rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Pin the model against hand-written lines.
    model_line(3, 45, 23);
    cmp_lit("pin_45_23", lzb ? "RH: 45%,T : 23C\r\n" : "RH:045%,T :023C\r\n", 0);
    model_line(2, 150, 99);
    cmp_lit("pin_clamp", "RH:99%,T :99C\r\n", 0);
    model_line(3, 5, 0);
    cmp_lit("pin_5_0", lzb ? "RH:  5%,T :  0C\r\n" : "RH:005%,T :000C\r\n", 0);

    // Basic line, full-rate sink.
    got0_q.delete();
    do_start(0, 45, 23);
    wait_done(0);
    cmp_lit("line_45_23", lzb ? "RH: 45%,T : 23C\r\n" : "RH:045%,T :023C\r\n", 1);

    // Backpressure patterns, random values.
    rmode[0] = 2;
    for (int k = 0; k < 3; k++) begin do_start(0, $urandom_range(0, 255), $urandom_range(0, 255)); wait_done(0); end
    rmode[0] = 1;
    for (int k = 0; k < 4; k++) begin do_start(0, $urandom_range(0, 255), $urandom_range(0, 255)); wait_done(0); end

    // Start while busy: during conversion and during emission.
    rmode[0] = 0;
    do_start(0, 200, 7);
    repeat (4) @(posedge clk);
    pulse_start(0);
    repeat (12) @(posedge clk);
    pulse_start(0);
    wait_done(0);
    do_start(0, 1, 100);
    wait_done(0);

    // Start coinciding with the LF transfer is an overrun, not a new line.
    do_start(0, 9, 99);
    n = 0;
    @(negedge clk);
    while (!(tx_valid[0] && tx_data[0] == 8'h0D) && n < 200) begin @(negedge clk); n++; end
    pulse_start(0);
    wait_done(0);
    repeat (3) @(posedge clk);

    // Clamping on the two-digit instance.
    do_start(1, 150, 99);
    wait_done(1);
    chk("sat_clamp", 1, sat_seen[1], 1);
    do_start(1, 99, 99);
    wait_done(1);
    chk("sat_exact_max", 1, sat_seen[1], 1);
    rmode[1] = 1;
    for (int k = 0; k < 4; k++) begin do_start(1, $urandom_range(0, 255), $urandom_range(0, 120)); wait_done(1); end

    // Reset during the second field, then a fresh line.
    rmode[0] = 0;
    do_start(0, 123, 231);
    repeat (30) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    got0_q.delete();
    do_start(0, 5, 0);
    wait_done(0);
    cmp_lit("line_5_0", lzb ? "RH:  5%,T :  0C\r\n" : "RH:005%,T :000C\r\n", 1);

    chk("sat_count", 0, sat_seen[0], exp_sat[0]);
    chk("sat_count", 1, sat_seen[1], exp_sat[1]);
    chk("q_empty", 0, exp_q0.size(), 0);
    chk("q_empty", 1, exp_q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
